// File: rtl/pipe_hold_ctrl.sv
// Pipeline hold / redirect controller.
// Arbitrates interrupt, jump, divider, bus and load-use requests.
module pipe_hold_ctrl #(
    parameter int FLUSH_CYCLES = 1,
    parameter int ADDR_W       = 32,
    parameter int CNT_W        = 32
) (
    input  logic              clk_i,
    input  logic              rst_n_i,
    input  logic              int_assert_i,
    input  logic [ADDR_W-1:0] int_addr_i,
    input  logic              jump_req_i,
    input  logic [ADDR_W-1:0] jump_addr_i,
    input  logic              ex_hold_req_i,
    input  logic              bus_hold_req_i,
    input  logic              load_use_i,
    output logic [2:0]        hold_flag_o,
    output logic              jump_flag_o,
    output logic [ADDR_W-1:0] jump_addr_o,
    output logic [CNT_W-1:0]  stall_cnt_o
);

    typedef enum logic [1:0] {
        S_RUN,
        S_FLUSH,
        S_DIV_WAIT,
        S_BUS_WAIT
    } state_t;

    localparam logic [2:0] HOLD_NONE  = 3'd0;
    localparam logic [2:0] HOLD_PC    = 3'd1;
    localparam logic [2:0] HOLD_ID_EX = 3'd3;

    localparam logic [2:0] FC_LAST =
        (FLUSH_CYCLES > 0) ? 3'(FLUSH_CYCLES - 1) : 3'd0;
    localparam state_t AFTER_JUMP =
        (FLUSH_CYCLES > 0) ? S_FLUSH : S_RUN;

    state_t            state_q, state_d;
    logic [2:0]        fcnt_q, fcnt_d;
    logic              pend_q, pend_d;
    logic [ADDR_W-1:0] pend_addr_q, pend_addr_d;
    logic [CNT_W-1:0]  stall_q;

    logic [2:0]        hold;
    logic              jf;
    logic [ADDR_W-1:0] ja;
    logic              run_eval;

    // Next-state and output decode; run_eval reuses the RUN arbitration
    always_comb begin
        hold        = HOLD_NONE;
        jf          = 1'b0;
        ja          = '0;
        state_d     = state_q;
        fcnt_d      = fcnt_q;
        pend_d      = pend_q;
        pend_addr_d = pend_addr_q;
        run_eval    = 1'b0;

        case (state_q)
            S_RUN: run_eval = 1'b1;
            S_FLUSH: begin
                hold = HOLD_ID_EX;
                if (int_assert_i) begin
                    jf     = 1'b1;
                    ja     = int_addr_i;
                    fcnt_d = 3'd0;
                end else if (fcnt_q == FC_LAST) begin
                    state_d = S_RUN;
                    fcnt_d  = 3'd0;
                end else begin
                    fcnt_d = fcnt_q + 3'd1;
                end
            end
            S_DIV_WAIT: begin
                if (ex_hold_req_i) hold = HOLD_ID_EX;
                else               run_eval = 1'b1;
            end
            S_BUS_WAIT: begin
                if (bus_hold_req_i) begin
                    hold = (pend_q || ex_hold_req_i) ? HOLD_ID_EX : HOLD_PC;
                    if (!pend_q && jump_req_i) begin
                        pend_d      = 1'b1;
                        pend_addr_d = jump_addr_i;
                        hold        = HOLD_ID_EX;
                    end
                end else if (int_assert_i) begin
                    hold    = HOLD_ID_EX;
                    jf      = 1'b1;
                    ja      = int_addr_i;
                    pend_d  = 1'b0;
                    state_d = AFTER_JUMP;
                    fcnt_d  = 3'd0;
                end else if (pend_q) begin
                    hold    = HOLD_ID_EX;
                    jf      = 1'b1;
                    ja      = pend_addr_q;
                    pend_d  = 1'b0;
                    state_d = AFTER_JUMP;
                    fcnt_d  = 3'd0;
                end else begin
                    run_eval = 1'b1;
                end
            end
            default: state_d = S_RUN;
        endcase

        if (run_eval) begin
            state_d = S_RUN;
            fcnt_d  = 3'd0;
            if (int_assert_i) begin
                hold    = HOLD_ID_EX;
                jf      = 1'b1;
                ja      = int_addr_i;
                state_d = AFTER_JUMP;
            end else if (jump_req_i && bus_hold_req_i) begin
                hold        = HOLD_ID_EX;
                pend_d      = 1'b1;
                pend_addr_d = jump_addr_i;
                state_d     = S_BUS_WAIT;
            end else if (jump_req_i) begin
                hold    = HOLD_ID_EX;
                jf      = 1'b1;
                ja      = jump_addr_i;
                state_d = AFTER_JUMP;
            end else if (ex_hold_req_i) begin
                hold    = HOLD_ID_EX;
                state_d = S_DIV_WAIT;
            end else if (bus_hold_req_i) begin
                hold    = HOLD_PC;
                state_d = S_BUS_WAIT;
            end else if (load_use_i) begin
                hold = HOLD_ID_EX;
            end
        end
    end

    // Controller state and pending redirect registers
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q     <= S_RUN;
            fcnt_q      <= 3'd0;
            pend_q      <= 1'b0;
            pend_addr_q <= '0;
        end else begin
            state_q     <= state_d;
            fcnt_q      <= fcnt_d;
            pend_q      <= pend_d;
            pend_addr_q <= pend_addr_d;
        end
    end

    // Saturating count of held cycles
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            stall_q <= '0;
        end else if (hold != HOLD_NONE && stall_q != '1) begin
            stall_q <= stall_q + 1'b1;
        end
    end

    // Outputs forced quiet while reset is asserted
    assign hold_flag_o = rst_n_i ? hold : HOLD_NONE;
    assign jump_flag_o = rst_n_i & jf;
    assign jump_addr_o = rst_n_i ? ja : '0;
    assign stall_cnt_o = stall_q;

endmodule

// File: tb/tb_pipe_hold_ctrl.sv
// Testbench for pipe_hold_ctrl.
// Directed vector table plus reset corner sequences.
module tb_pipe_hold_ctrl;

    logic        clk;
    logic        rst_n;
    logic        ia;
    logic [31:0] iaddr;
    logic        jr;
    logic [31:0] jaddr;
    logic        eh;
    logic        bh;
    logic        lu;
    logic [2:0]  hold;
    logic        jf;
    logic [31:0] ja;
    logic [31:0] scnt;
    logic [2:0]  hold4;
    logic        jf4;
    logic [31:0] ja4;
    logic [3:0]  scnt4;

    pipe_hold_ctrl #(.FLUSH_CYCLES(1), .ADDR_W(32), .CNT_W(32)) dut (
        .clk_i(clk), .rst_n_i(rst_n),
        .int_assert_i(ia), .int_addr_i(iaddr),
        .jump_req_i(jr), .jump_addr_i(jaddr),
        .ex_hold_req_i(eh), .bus_hold_req_i(bh),
        .load_use_i(lu),
        .hold_flag_o(hold), .jump_flag_o(jf),
        .jump_addr_o(ja), .stall_cnt_o(scnt)
    );

    pipe_hold_ctrl #(.FLUSH_CYCLES(1), .ADDR_W(32), .CNT_W(4)) dut4 (
        .clk_i(clk), .rst_n_i(rst_n),
        .int_assert_i(ia), .int_addr_i(iaddr),
        .jump_req_i(jr), .jump_addr_i(jaddr),
        .ex_hold_req_i(eh), .bus_hold_req_i(bh),
        .load_use_i(lu),
        .hold_flag_o(hold4), .jump_flag_o(jf4),
        .jump_addr_o(ja4), .stall_cnt_o(scnt4)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        ia;
        logic [31:0] iaddr;
        logic        jr;
        logic [31:0] jaddr;
        logic        eh;
        logic        bh;
        logic        lu;
        logic [2:0]  hold;
        logic        jf;
        logic [31:0] ja;
    } vec_t;

    vec_t tbl[$];
    int   npass = 0;
    int   ntotal = 0;
    int   exp_cnt = 0;

    task automatic chk(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
        ntotal++;
        if (act === exp) npass++;
        else $display("FAIL %s got %0h exp %0h", name, act, exp);
    endtask

    function automatic vec_t mk(
        input logic i, input logic [31:0] ida,
        input logic j, input logic [31:0] jda,
        input logic e, input logic b, input logic l,
        input logic [2:0] h, input logic f, input logic [31:0] a);
        vec_t v;
        v.ia = i; v.iaddr = ida; v.jr = j; v.jaddr = jda;
        v.eh = e; v.bh = b; v.lu = l;
        v.hold = h; v.jf = f; v.ja = a;
        return v;
    endfunction

    task automatic idle_in();
        ia = 0; iaddr = 0; jr = 0; jaddr = 0;
        eh = 0; bh = 0; lu = 0;
    endtask

    initial begin
        //            ia iaddr   jr jaddr   eh bh lu hold jf ja
        tbl.push_back(mk(0, 0,     0, 0,     0, 0, 0, 0, 0, 0));
        tbl.push_back(mk(0, 0,     1, 'h100, 0, 0, 0, 3, 1, 'h100));
        tbl.push_back(mk(0, 0,     0, 0,     0, 0, 0, 3, 0, 0));
        tbl.push_back(mk(0, 0,     0, 0,     0, 0, 0, 0, 0, 0));
        for (int k = 0; k < 5; k++)
            tbl.push_back(mk(0, 0, 0, 0,     1, 0, 0, 3, 0, 0));
        tbl.push_back(mk(0, 0,     0, 0,     0, 0, 0, 0, 0, 0));
        tbl.push_back(mk(0, 0,     1, 'h200, 0, 1, 0, 3, 0, 0));
        tbl.push_back(mk(0, 0,     0, 0,     0, 1, 0, 3, 0, 0));
        tbl.push_back(mk(0, 0,     0, 0,     0, 1, 0, 3, 0, 0));
        tbl.push_back(mk(0, 0,     0, 0,     0, 0, 0, 3, 1, 'h200));
        tbl.push_back(mk(0, 0,     0, 0,     0, 0, 0, 3, 0, 0));
        tbl.push_back(mk(1, 'h80,  1, 'h300, 0, 0, 0, 3, 1, 'h80));
        tbl.push_back(mk(0, 0,     1, 'h400, 0, 0, 0, 3, 0, 0));
        tbl.push_back(mk(0, 0,     0, 0,     0, 0, 1, 3, 0, 0));
        tbl.push_back(mk(0, 0,     0, 0,     0, 0, 0, 0, 0, 0));
        tbl.push_back(mk(0, 0,     0, 0,     0, 0, 1, 3, 0, 0));
        tbl.push_back(mk(0, 0,     0, 0,     0, 0, 1, 3, 0, 0));
        tbl.push_back(mk(0, 0,     0, 0,     0, 0, 0, 0, 0, 0));
        tbl.push_back(mk(0, 0,     0, 0,     0, 1, 0, 1, 0, 0));
        tbl.push_back(mk(0, 0,     0, 0,     0, 1, 0, 1, 0, 0));
        tbl.push_back(mk(0, 0,     0, 0,     0, 0, 0, 0, 0, 0));
        tbl.push_back(mk(0, 0,     1, 'h500, 0, 1, 0, 3, 0, 0));
        tbl.push_back(mk(1, 'h90,  0, 0,     0, 1, 0, 3, 0, 0));
        tbl.push_back(mk(1, 'h90,  0, 0,     0, 0, 0, 3, 1, 'h90));
        tbl.push_back(mk(0, 0,     0, 0,     0, 0, 0, 3, 0, 0));
        tbl.push_back(mk(0, 0,     0, 0,     0, 0, 0, 0, 0, 0));
        tbl.push_back(mk(0, 0,     1, 'h600, 0, 0, 0, 3, 1, 'h600));
        tbl.push_back(mk(1, 'hA0,  0, 0,     0, 0, 0, 3, 1, 'hA0));
        tbl.push_back(mk(0, 0,     0, 0,     0, 0, 0, 3, 0, 0));
        tbl.push_back(mk(0, 0,     0, 0,     0, 0, 0, 0, 0, 0));
        tbl.push_back(mk(0, 0,     0, 0,     1, 0, 0, 3, 0, 0));
        tbl.push_back(mk(1, 'hB0,  0, 0,     1, 0, 0, 3, 0, 0));
        tbl.push_back(mk(0, 0,     1, 'h700, 0, 0, 0, 3, 1, 'h700));
        tbl.push_back(mk(0, 0,     0, 0,     0, 0, 0, 3, 0, 0));
        tbl.push_back(mk(0, 0,     0, 0,     0, 0, 0, 0, 0, 0));

        idle_in();
        rst_n = 1'b0;
        #1;
        chk("rst_hold", 64'(hold), 0);
        chk("rst_jf", 64'(jf), 0);
        chk("rst_ja", 64'(ja), 0);
        chk("rst_cnt", 64'(scnt), 0);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < tbl.size(); i++) begin
            @(negedge clk);
            ia = tbl[i].ia; iaddr = tbl[i].iaddr;
            jr = tbl[i].jr; jaddr = tbl[i].jaddr;
            eh = tbl[i].eh; bh = tbl[i].bh; lu = tbl[i].lu;
            #1;
            chk($sformatf("v%0d_hold", i), 64'(hold), 64'(tbl[i].hold));
            chk($sformatf("v%0d_jf", i), 64'(jf), 64'(tbl[i].jf));
            chk($sformatf("v%0d_ja", i), 64'(ja), 64'(tbl[i].ja));
            chk($sformatf("v%0d_cnt", i), 64'(scnt), 64'(exp_cnt));
            chk($sformatf("v%0d_cnt4", i), 64'(scnt4),
                64'((exp_cnt > 15) ? 15 : exp_cnt));
            if (tbl[i].hold != 0) exp_cnt++;
        end

        // async reset in the middle of a divide
        @(negedge clk);
        idle_in();
        eh = 1'b1;
        #1 chk("div_hold", 64'(hold), 3);
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("divrst_hold", 64'(hold), 0);
        chk("divrst_jf", 64'(jf), 0);
        chk("divrst_cnt", 64'(scnt), 0);
        chk("divrst_cnt4", 64'(scnt4), 0);
        eh = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        #1 chk("divrel_hold", 64'(hold), 0);

        // pending redirect lost across reset
        @(negedge clk);
        jr = 1'b1; jaddr = 'h800; bh = 1'b1;
        #1 chk("pend_hold", 64'(hold), 3);
        chk("pend_jf", 64'(jf), 0);
        @(posedge clk);
        #2 rst_n = 1'b0;
        idle_in();
        #1 chk("pendrst_cnt", 64'(scnt), 0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("pendrel_jf", 64'(jf), 0);
        chk("pendrel_hold", 64'(hold), 0);
        @(negedge clk);
        #1;
        chk("pendpost_jf", 64'(jf), 0);
        chk("pendpost_ja", 64'(ja), 0);
        chk("pendpost_cnt", 64'(scnt), 0);

        $display("%0d/%0d checks passed", npass, ntotal);
        $finish;
    end

endmodule
